// File: rtl/ray_pkg.sv
// Shared types and helpers for the ray-generation receive path.
// Contents: collector FSM state type, default data widths, and the
// op_code -> active core count decode.
package ray_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } collector_state_t;

  localparam int unsigned PIXEL_W_DEF = 24;
  localparam int unsigned INDEX_W_DEF = 32;

  // Active core count N = op_code + 1 (1..4).
  function automatic logic [2:0] ncores(input logic [1:0] op_code);
    return {1'b0, op_code} + 3'd1;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous per-core result FIFO holding {index, pixel} words.
// Ports:
//   clk, reset_n   clock, synchronous active-high reset
//   clear          synchronous flush (drops all entries)
//   wr_en/wr_data  push side; ignored while full
//   rd_en/rd_data  pop side; rd_data is the current head, ignored while empty
//   full, empty    occupancy flags
module result_fifo #(
  parameter int unsigned WIDTH = 56,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  // Full is checked before the pop of the same cycle, so no pass-through.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_next(wr_ptr);
      if (do_rd) rd_ptr <= ptr_next(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pixel_collector.sv
// Collects interleaved per-core shading results and re-emits them as a
// single raster-ordered video stream.
// Ports:
//   clk, reset_n                     clock, synchronous active-high reset
//   start, op_code, image_*          frame setup, sampled in IDLE
//   res_valid/res_ready/res_pixel/res_index   per-core result inputs (packed)
//   m_valid/m_ready/m_data/m_user/m_last      output video stream
//   busy, frame_done, index_error    status
module pixel_collector
  import ray_pkg::*;
#(
  parameter int unsigned MAX_CORES = 8,
  parameter int unsigned PIXEL_W   = PIXEL_W_DEF,
  parameter int unsigned INDEX_W   = INDEX_W_DEF,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [1:0]                   op_code,
  input  logic [12:0]                  image_width,
  input  logic [12:0]                  image_height,
  input  logic [MAX_CORES-1:0]         res_valid,
  output logic [MAX_CORES-1:0]         res_ready,
  input  logic [MAX_CORES*PIXEL_W-1:0] res_pixel,
  input  logic [MAX_CORES*INDEX_W-1:0] res_index,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [PIXEL_W-1:0]           m_data,
  output logic                         m_user,
  output logic                         m_last,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         index_error
);

  localparam int unsigned CUR_W  = (MAX_CORES > 1) ? $clog2(MAX_CORES) : 1;
  localparam int unsigned N_W    = CUR_W + 1;
  localparam int unsigned DW     = INDEX_W + PIXEL_W;
  localparam int unsigned PROD_W = 26;

  collector_state_t state_q;
  collector_state_t state_d;

  logic [N_W-1:0]     n_q;
  logic [INDEX_W-1:0] total_q;
  logic [INDEX_W-1:0] expect_q;
  logic [CUR_W-1:0]   cur_q;

  logic [PROD_W-1:0]  frame_prod;
  logic [INDEX_W-1:0] frame_total;
  logic               start_frame;
  logic               running;
  logic               pop;
  logic               last_beat;

  logic [MAX_CORES-1:0] core_active;
  logic [MAX_CORES-1:0] fifo_wr;
  logic [MAX_CORES-1:0] fifo_rd;
  logic [MAX_CORES-1:0] fifo_full;
  logic [MAX_CORES-1:0] fifo_empty;
  logic [DW-1:0]        fifo_head [MAX_CORES];

  logic [DW-1:0]      head;
  logic [INDEX_W-1:0] head_index;
  logic [PIXEL_W-1:0] head_pixel;

  assign frame_prod  = PROD_W'(image_width) * PROD_W'(image_height);
  assign frame_total = INDEX_W'(frame_prod);

  assign running    = (state_q == RUN);
  assign head       = fifo_head[cur_q];
  assign head_index = head[DW-1 -: INDEX_W];
  assign head_pixel = head[PIXEL_W-1:0];
  assign last_beat  = (expect_q == total_q - INDEX_W'(1));

  // Output stream is the head of the FIFO owning the next raster index.
  assign m_valid = running && !fifo_empty[cur_q];
  assign m_data  = m_valid ? head_pixel : '0;
  assign m_user  = m_valid && (expect_q == '0);
  assign m_last  = m_valid && last_beat;
  assign pop     = m_valid && m_ready;

  assign busy       = running;
  assign frame_done = (state_q == DONE);

  // Per-core FIFOs; only the first N cores accept results, and only in RUN.
  for (genvar k = 0; k < MAX_CORES; k++) begin : g_core
    assign core_active[k] = (N_W'(k) < n_q);
    assign res_ready[k]   = running && core_active[k] && !fifo_full[k];
    assign fifo_wr[k]     = res_valid[k] && res_ready[k];
    assign fifo_rd[k]     = pop && (cur_q == CUR_W'(k));

    result_fifo #(
      .WIDTH (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (start_frame),
      .wr_en   (fifo_wr[k]),
      .wr_data ({res_index[k*INDEX_W +: INDEX_W], res_pixel[k*PIXEL_W +: PIXEL_W]}),
      .rd_en   (fifo_rd[k]),
      .rd_data (fifo_head[k]),
      .full    (fifo_full[k]),
      .empty   (fifo_empty[k])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_frame = 1'b1;
          state_d     = (frame_prod == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (pop && last_beat) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame parameters, raster counters and sticky tag check.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      n_q         <= '0;
      total_q     <= '0;
      expect_q    <= '0;
      cur_q       <= '0;
      index_error <= 1'b0;
    end else if (start_frame) begin
      n_q         <= N_W'(ncores(op_code));
      total_q     <= frame_total;
      expect_q    <= '0;
      cur_q       <= '0;
      index_error <= 1'b0;
    end else if (pop) begin
      expect_q <= expect_q + INDEX_W'(1);
      // Round-robin wrap at N avoids a modulo on the raster index.
      cur_q    <= (cur_q == CUR_W'(n_q - N_W'(1))) ? '0 : cur_q + CUR_W'(1);
      if (head_index != expect_q) index_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_collector.sv
module tb_pixel_collector;

  localparam int unsigned MAX_CORES = 8;
  localparam int unsigned PIXEL_W   = 24;
  localparam int unsigned INDEX_W   = 32;

  logic                         clk = 1'b0;
  logic                         reset_n;
  logic                         start;
  logic [1:0]                   op_code;
  logic [12:0]                  image_width;
  logic [12:0]                  image_height;
  logic [MAX_CORES-1:0]         res_valid;
  logic [MAX_CORES-1:0]         res_ready;
  logic [MAX_CORES*PIXEL_W-1:0] res_pixel;
  logic [MAX_CORES*INDEX_W-1:0] res_index;
  logic                         m_valid;
  logic                         m_ready;
  logic [PIXEL_W-1:0]           m_data;
  logic                         m_user;
  logic                         m_last;
  logic                         busy;
  logic                         frame_done;
  logic                         index_error;

  int checks = 0;
  int passed = 0;
  bit abort  = 1'b0;

  logic [PIXEL_W-1:0] got_d [$];
  logic               got_u [$];
  logic               got_l [$];

  pixel_collector dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .op_code      (op_code),
    .image_width  (image_width),
    .image_height (image_height),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_pixel    (res_pixel),
    .res_index    (res_index),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_user       (m_user),
    .m_last       (m_last),
    .busy         (busy),
    .frame_done   (frame_done),
    .index_error  (index_error)
  );

  always #5 clk = ~clk;

  function automatic logic [PIXEL_W-1:0] pix(input int i);
    return PIXEL_W'(i * 32'h010101);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] op, input logic [12:0] w, input logic [12:0] h);
    op_code      = op;
    image_width  = w;
    image_height = h;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // One core sending count results: first, first+step, ...; bad_idx>=0 replaces the first tag.
  task automatic feed(input int core, input int delay, input int first, input int step,
                      input int count, input int bad_idx);
    int  sent = 0;
    int  cyc  = 0;
    int  idx;
    logic ok;
    repeat (delay) tick();
    while (sent < count && cyc < 400 && !abort) begin
      idx = first + sent * step;
      res_valid[core] = 1'b1;
      res_pixel[core*PIXEL_W +: PIXEL_W] = pix(idx);
      res_index[core*INDEX_W +: INDEX_W] = (sent == 0 && bad_idx >= 0) ? 32'(bad_idx) : 32'(idx);
      ok = res_ready[core];
      tick();
      cyc++;
      if (ok) sent++;
    end
    res_valid[core] = 1'b0;
  endtask

  // Sink: records accepted beats; mode 1 drives m_ready as 1,0,0 repeating.
  task automatic collect(input int nbeats, input int mode, input int budget,
                         output int beats, output int stab_err);
    int cyc = 0;
    logic pv = 1'b0, pr = 1'b1, pu = 1'b0, pl = 1'b0;
    logic [PIXEL_W-1:0] pd = '0;
    beats = 0;
    stab_err = 0;
    got_d.delete(); got_u.delete(); got_l.delete();
    while (beats < nbeats && cyc < budget) begin
      if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd || m_user !== pu || m_last !== pl))
        stab_err++;
      m_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_u.push_back(m_user);
        got_l.push_back(m_last);
        beats++;
      end
      pv = m_valid; pr = m_ready; pd = m_data; pu = m_user; pl = m_last;
      tick();
      cyc++;
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; start = 1'b0; op_code = '0; image_width = '0; image_height = '0;
    res_valid = '0; res_pixel = '0; res_index = '0; m_ready = 1'b0;
    tick(); tick(); tick();
    checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got=%b exp=0", m_valid); else passed++;
    checks++; if (m_data !== '0) $display("FAIL reset_m_data got=%h exp=0", m_data); else passed++;
    checks++; if (m_user !== 1'b0) $display("FAIL reset_m_user got=%b exp=0", m_user); else passed++;
    checks++; if (m_last !== 1'b0) $display("FAIL reset_m_last got=%b exp=0", m_last); else passed++;
    checks++; if (res_ready !== '0) $display("FAIL reset_res_ready got=%h exp=0", res_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b exp=0", frame_done); else passed++;
    checks++; if (index_error !== 1'b0) $display("FAIL reset_index_error got=%b exp=0", index_error); else passed++;
    reset_n = 1'b0;
    tick();
  endtask

  task automatic test_single_core();
    int beats, se;
    do_start(2'd0, 13'd4, 13'd2);
    checks++; if (busy !== 1'b1) $display("FAIL t1_busy got=%b exp=1", busy); else passed++;
    fork
      feed(0, 0, 0, 1, 8, -1);
      collect(8, 0, 100, beats, se);
    join
    checks++; if (beats != 8) $display("FAIL t1_beats got=%0d exp=8", beats); else passed++;
    checks++; if (frame_done !== 1'b1) $display("FAIL t1_frame_done got=%b exp=1", frame_done); else passed++;
    for (int i = 0; i < beats; i++) begin
      checks++; if (got_d[i] !== pix(i)) $display("FAIL t1_data[%0d] got=%h exp=%h", i, got_d[i], pix(i)); else passed++;
      checks++; if (got_u[i] !== (i == 0)) $display("FAIL t1_user[%0d] got=%b exp=%b", i, got_u[i], (i == 0)); else passed++;
      checks++; if (got_l[i] !== (i == 7)) $display("FAIL t1_last[%0d] got=%b exp=%b", i, got_l[i], (i == 7)); else passed++;
    end
    checks++; if (index_error !== 1'b0) $display("FAIL t1_index_error got=%b exp=0", index_error); else passed++;
    tick();
    checks++; if (frame_done !== 1'b0) $display("FAIL t1_frame_done_pulse got=%b exp=0", frame_done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL t1_busy_idle got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_out_of_order();
    int beats, se;
    do_start(2'd3, 13'd4, 13'd4);
    fork
      feed(3, 0, 3, 4, 4, -1);
      feed(2, 10, 2, 4, 4, -1);
      feed(1, 20, 1, 4, 4, -1);
      feed(0, 30, 0, 4, 4, -1);
      collect(16, 0, 300, beats, se);
      begin
        repeat (8) tick();
        checks++; if (res_ready[3] !== 1'b0) $display("FAIL t2_core3_full got=%b exp=0", res_ready[3]); else passed++;
        checks++; if (res_ready[2] !== 1'b1) $display("FAIL t2_core2_ready got=%b exp=1", res_ready[2]); else passed++;
        checks++; if (res_ready[7:4] !== 4'b0) $display("FAIL t2_inactive_ready got=%h exp=0", res_ready[7:4]); else passed++;
        checks++; if (m_valid !== 1'b0) $display("FAIL t2_no_early_out got=%b exp=0", m_valid); else passed++;
      end
    join
    checks++; if (beats != 16) $display("FAIL t2_beats got=%0d exp=16", beats); else passed++;
    for (int i = 0; i < beats; i++) begin
      checks++; if (got_d[i] !== pix(i)) $display("FAIL t2_data[%0d] got=%h exp=%h", i, got_d[i], pix(i)); else passed++;
    end
    checks++; if (frame_done !== 1'b1) $display("FAIL t2_frame_done got=%b exp=1", frame_done); else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    int beats, se;
    do_start(2'd1, 13'd2, 13'd2);
    fork
      feed(0, 0, 0, 2, 2, -1);
      feed(1, 0, 1, 2, 2, -1);
      collect(4, 1, 100, beats, se);
    join
    checks++; if (beats != 4) $display("FAIL t3_beats got=%0d exp=4", beats); else passed++;
    checks++; if (se != 0) $display("FAIL t3_stability got=%0d exp=0", se); else passed++;
    for (int i = 0; i < beats; i++) begin
      checks++; if (got_d[i] !== pix(i)) $display("FAIL t3_data[%0d] got=%h exp=%h", i, got_d[i], pix(i)); else passed++;
    end
    checks++; if (got_l[3] !== 1'b1) $display("FAIL t3_last got=%b exp=1", got_l[3]); else passed++;
    checks++; if (frame_done !== 1'b1) $display("FAIL t3_frame_done got=%b exp=1", frame_done); else passed++;
    m_ready = 1'b1;
    tick();
    checks++; if (m_valid !== 1'b0) $display("FAIL t3_no_extra_beat got=%b exp=0", m_valid); else passed++;
    m_ready = 1'b0;
  endtask

  task automatic test_tag_error();
    int beats, se;
    do_start(2'd3, 13'd4, 13'd1);
    fork
      feed(0, 0, 0, 1, 1, -1);
      feed(1, 0, 1, 1, 1, 5);
      feed(2, 0, 2, 1, 1, -1);
      feed(3, 0, 3, 1, 1, -1);
      collect(4, 0, 100, beats, se);
    join
    checks++; if (beats != 4) $display("FAIL t4_beats got=%0d exp=4", beats); else passed++;
    for (int i = 0; i < beats; i++) begin
      checks++; if (got_d[i] !== pix(i)) $display("FAIL t4_data[%0d] got=%h exp=%h", i, got_d[i], pix(i)); else passed++;
    end
    checks++; if (index_error !== 1'b1) $display("FAIL t4_index_error got=%b exp=1", index_error); else passed++;
    repeat (4) tick();
    checks++; if (index_error !== 1'b1) $display("FAIL t4_index_error_sticky got=%b exp=1", index_error); else passed++;
  endtask

  task automatic test_zero_size();
    res_valid = '1;
    do_start(2'd0, 13'd0, 13'd5);
    checks++; if (frame_done !== 1'b1) $display("FAIL t6_frame_done got=%b exp=1", frame_done); else passed++;
    checks++; if (m_valid !== 1'b0) $display("FAIL t6_m_valid got=%b exp=0", m_valid); else passed++;
    checks++; if (res_ready !== '0) $display("FAIL t6_res_ready got=%h exp=0", res_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL t6_busy got=%b exp=0", busy); else passed++;
    checks++; if (index_error !== 1'b0) $display("FAIL t6_index_error_cleared got=%b exp=0", index_error); else passed++;
    tick();
    checks++; if (frame_done !== 1'b0) $display("FAIL t6_frame_done_pulse got=%b exp=0", frame_done); else passed++;
    checks++; if (res_ready !== '0) $display("FAIL t6_res_ready_idle got=%h exp=0", res_ready); else passed++;
    res_valid = '0;
  endtask

  task automatic test_mid_frame_reset();
    int beats, se;
    do_start(2'd2, 13'd8, 13'd8);
    fork
      begin
        fork
          feed(0, 0, 0, 3, 22, -1);
          feed(1, 0, 1, 3, 21, -1);
          feed(2, 0, 2, 3, 21, -1);
        join
      end
      begin
        collect(5, 0, 100, beats, se);
        abort   = 1'b1;
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        checks++; if (m_valid !== 1'b0) $display("FAIL t5_m_valid got=%b exp=0", m_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL t5_busy got=%b exp=0", busy); else passed++;
        checks++; if (res_ready !== '0) $display("FAIL t5_res_ready got=%h exp=0", res_ready); else passed++;
      end
    join
    abort = 1'b0;
    checks++; if (beats != 5) $display("FAIL t5_partial_beats got=%0d exp=5", beats); else passed++;
    tick();
    do_start(2'd2, 13'd8, 13'd8);
    fork
      feed(0, 0, 0, 3, 22, -1);
      feed(1, 0, 1, 3, 21, -1);
      feed(2, 0, 2, 3, 21, -1);
      collect(64, 0, 500, beats, se);
    join
    checks++; if (beats != 64) $display("FAIL t5_beats got=%0d exp=64", beats); else passed++;
    for (int i = 0; i < beats; i++) begin
      checks++; if (got_d[i] !== pix(i)) $display("FAIL t5_data[%0d] got=%h exp=%h", i, got_d[i], pix(i)); else passed++;
    end
    if (beats == 64) begin
      checks++; if (got_u[0] !== 1'b1) $display("FAIL t5_user got=%b exp=1", got_u[0]); else passed++;
      checks++; if (got_l[63] !== 1'b1) $display("FAIL t5_last got=%b exp=1", got_l[63]); else passed++;
    end
    checks++; if (frame_done !== 1'b1) $display("FAIL t5_frame_done got=%b exp=1", frame_done); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_core();
    test_out_of_order();
    test_backpressure();
    test_tag_error();
    test_zero_size();
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
